// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Feature macro consumed by the top: WB_ZERO_REG_FILTER_EN.
package wb_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned CNT_MAX    = 15;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } prio_e;

endpackage

// File: rtl/wb_prio_fsm.sv
// Priority FSM plus saturating starve counter for requester B.
// B gains conflict priority once it has lost STARVE_LIMIT conflicts in a row.
module wb_prio_fsm
  import wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_b_req,
  input  logic  i_b_ack,
  output prio_e o_state
);

  prio_e              r_state;
  prio_e              w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PRI_A;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Switch on the post-edge count so B wins exactly after STARVE_LIMIT losses.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    if (i_b_ack) begin
      w_cnt_nxt = '0;
    end else if (i_b_req && (r_cnt != CNT_W'(CNT_MAX))) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    case (r_state)
      PRI_A:   if (w_cnt_nxt >= CNT_W'(STARVE_LIMIT)) w_state_nxt = PRI_B;
      PRI_B:   if (i_b_ack) w_state_nxt = PRI_A;
      default: w_state_nxt = PRI_A;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file write-back arbiter with anti-starvation priority.
// Optional WB_ZERO_REG_FILTER_EN suppresses the write enable for register 0.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_sel
);

  prio_e             w_state;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_grant;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_sel;

  wb_prio_fsm #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_b_req (b_req),
    .i_b_ack (w_grant_b),
    .o_state (w_state)
  );

  // Grant: lone requester always wins; conflicts resolved by priority state.
  always_comb begin
    w_grant_b = rst_n && b_req && (!a_req || (w_state == PRI_B));
    w_grant_a = rst_n && a_req && !w_grant_b;
    w_grant   = w_grant_a || w_grant_b;
    w_addr    = w_grant_b ? b_addr : a_addr;
    w_data    = w_grant_b ? b_data : a_data;
`ifdef WB_ZERO_REG_FILTER_EN
    w_we      = w_grant && (w_addr != '0);
`else
    w_we      = w_grant;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_we <= w_we;
      if (w_grant) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
        r_sel   <= w_grant_b;
      end
    end
  end

  assign a_ack    = w_grant_a;
  assign b_ack    = w_grant_b;
  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign rf_sel   = r_sel;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed steps push expected writes,
// a posedge monitor pops and compares them against the register-file port.
module tb_regfile_wb_arbiter;

`ifdef WB_ZERO_REG_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ack, b_ack;
  logic        rf_we, rf_sel;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  regfile_wb_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ack    (a_ack),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ack    (b_ack),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_sel   (rf_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One arbitration cycle: drive at negedge, check acks, queue expected writes.
  task automatic step(input logic ar, input logic [4:0] aa, input logic [31:0] ad,
                      input logic br, input logic [4:0] ba, input logic [31:0] bd,
                      input logic ea, input logic eb, input string name);
    exp_t e;
    @(negedge clk);
    a_req = ar; a_addr = aa; a_data = ad;
    b_req = br; b_addr = ba; b_data = bd;
    #1;
    chk({name, ".a_ack"}, 32'(a_ack), 32'(ea));
    chk({name, ".b_ack"}, 32'(b_ack), 32'(eb));
    if (ea && !(FILT && aa == 5'd0)) begin
      e.addr = aa; e.data = ad; e.sel = 1'b0; q.push_back(e);
    end
    if (eb && !(FILT && ba == 5'd0)) begin
      e.addr = ba; e.data = bd; e.sel = 1'b1; q.push_back(e);
    end
  endtask

  task automatic idle(input string name);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, name);
  endtask

  // Monitor: every issued write must match the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rf_we) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%h sel=%b exp none",
                 rf_waddr, rf_wdata, rf_sel);
      end else begin
        e = q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data || rf_sel !== e.sel) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h sel=%b exp addr=%0d data=%h sel=%b",
                   rf_waddr, rf_wdata, rf_sel, e.addr, e.data, e.sel);
        end
      end
    end else if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_write got rf_we=0 exp addr=%0d data=%h sel=%b",
               e.addr, e.data, e.sel);
    end
  end

  initial begin
    rst_n = 1'b0;
    a_req = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA_0000;
    b_req = 1'b1; b_addr = 5'd4; b_data = 32'hBBBB_0000;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.a_ack", 32'(a_ack), 32'd0);
    chk("rst.b_ack", 32'(b_ack), 32'd0);
    chk("rst.rf_we", 32'(rf_we), 32'd0);
    chk("rst.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst.rf_wdata", rf_wdata, 32'd0);
    chk("rst.rf_sel", 32'(rf_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;

    // Single A write, then single B write to r31.
    step(1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "a_single");
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0, 1'b1, "b_single");
    idle("idle0");
    idle("idle1");
    @(posedge clk);
    #2;
    chk("hold.rf_we", 32'(rf_we), 32'd0);
    chk("hold.rf_sel", 32'(rf_sel), 32'd1);
    chk("hold.rf_waddr", 32'(rf_waddr), 32'd31);
    chk("hold.rf_wdata", rf_wdata, 32'hDEAD_BEEF);

    // Continuous contention: four A grants then one B grant, twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        step(1'b1, 5'(i + 1), 32'(32'h100 + r * 16 + i), 1'b1, 5'd20, 32'(32'hB0 + r),
             1'b1, 1'b0, "contend_a");
      step(1'b1, 5'd9, 32'h9999, 1'b1, 5'd20, 32'(32'hB0 + r), 1'b0, 1'b1, "contend_b");
    end

    // Register-zero write from A.
    step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "a_zero");
    idle("idle2");

    // Starve B twice, issue one more A write, then reset mid-flight.
    step(1'b1, 5'd6, 32'h600, 1'b1, 5'd7, 32'h700, 1'b1, 1'b0, "pre_rst0");
    step(1'b1, 5'd6, 32'h601, 1'b1, 5'd7, 32'h700, 1'b1, 1'b0, "pre_rst1");
    step(1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "pre_rst2");
    @(posedge clk);
    #3;
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.rf_we", 32'(rf_we), 32'd0);
    chk("midrst.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("midrst.rf_sel", 32'(rf_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Starvation memory must be gone: again four A grants before B.
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd10, 32'(32'h200 + i), 1'b1, 5'd11, 32'h300, 1'b1, 1'b0, "post_rst_a");
    step(1'b1, 5'd10, 32'h2FF, 1'b1, 5'd11, 32'h300, 1'b0, 1'b1, "post_rst_b");
    idle("idle3");
    repeat (3) @(posedge clk);
    #2;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
